register_bank: RTL and testbench
================================

# register_bank

General-purpose register file of the MIPS pipeline: the receiving end of the writeback path. It accepts the selected writeback word, address and write strobe from the WB stage, serves the two ID-stage operand reads (rs, rt) with a same-cycle write-through bypass, and provides a debug dump engine. The dump engine streams all registers out over a valid/ready handshake to the debug unit.

## Interface
- NB_DATA, 32, register width in bits
- NB_ADDR, 5, register address width; the bank holds N_REGS = 2**NB_ADDR registers

- clock_i  in  1  system clock; all state changes on its rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- wb_data_i  in  NB_DATA  writeback data (output of the writeback select mux)
- wb_addr_i  in  NB_ADDR  destination register
- wb_write_i  in  1  write enable
- rs_addr_i  in  NB_ADDR  read port A address
- rt_addr_i  in  NB_ADDR  read port B address
- rs_data_o  out  NB_DATA  read port A data
- rt_data_o  out  NB_DATA  read port B data
- dump_start_i  in  1  request a full register dump (level sampled in IDLE)
- dump_ready_i  in  1  debug unit accepts the current dump beat
- dump_valid_o  out  1  dump beat valid
- dump_addr_o  out  NB_ADDR  index of the current dump beat
- dump_data_o  out  NB_DATA  contents of register dump_addr_o
- dump_busy_o  out  1  dump engine not in IDLE
- dump_done_o  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Register 0 reads as 0 always; writes to address 0 are discarded.
- Write: at a rising edge with wb_write_i=1 and wb_addr_i!=0, regs[wb_addr_i] <= wb_data_i.
- Read: combinational. If wb_write_i=1, wb_addr_i!=0 and wb_addr_i==rs_addr_i, then rs_data_o = wb_data_i (bypass); otherwise rs_data_o = regs[rs_addr_i]. rt follows the same rule independently.
- Dump FSM, states IDLE, SEND, DONE:
  - IDLE: dump_valid_o=0. If dump_start_i=1, go to SEND with idx=0.
  - SEND: dump_valid_o=1, dump_addr_o=idx, dump_data_o=regs[idx] (stored value, no bypass). On dump_valid_o && dump_ready_i: if idx==N_REGS-1, go to DONE; else idx<=idx+1. With dump_ready_i=0, addr is held and data tracks the stored register.
  - DONE: dump_done_o=1 for exactly one cycle, then IDLE.
- dump_start_i is ignored in SEND and DONE. If it is still high in IDLE, a new dump starts on the following edge.
- Writeback writes and operand reads are never blocked by the dump. A register written during a dump shows its new value in any beat presented after the write edge.

## Timing
- Reset (async assert, sync release): all regs=0, FSM=IDLE, idx=0. Outputs: dump_valid_o=0, dump_busy_o=0, dump_done_o=0, dump_addr_o=0, dump_data_o=0. rs/rt_data_o = 0 unless a bypass is active.
- Read latency: 0 cycles. A write becomes visible through storage on the cycle after its edge, and through the bypass in the same cycle.
- Dump: first beat valid on the cycle after dump_start_i is sampled in IDLE. With dump_ready_i held high, 32 beats take 32 cycles (NB_ADDR=5). dump_done_o follows in the next cycle, and IDLE is re-entered one cycle after that.
- Reset asserted mid-dump aborts immediately to IDLE. No dump_done_o is produced, and register contents are cleared.

## Structure
- Shared package: NB_DATA, NB_ADDR, N_REGS, and the dump FSM state encoding (IDLE=2'b00, SEND=2'b01, DONE=2'b10).
- One sub-module, reg_dump_ctrl: the FSM plus the idx counter and handshake. It outputs the dump index and control, and the top level muxes the register array to dump_data_o.

## Test plan
- Reset, then read all rs/rt addresses -> all 0; write addr 0 with 0xDEADBEEF -> reads of addr 0 remain 0.
- Write 0x12345678 to r5 with rs_addr_i=5 in the same cycle -> rs_data_o=0x12345678 that cycle via bypass, and from storage on the next cycle; rt_addr_i=5 gives the same result.
- Write r1..r31 with value 0x100+i, pulse dump_start_i, hold dump_ready_i=1 -> beats addr 0..31 with data 0, 0x101..0x11F on 32 consecutive cycles; dump_done_o pulses once; busy drops afterwards.
- Dump with dump_ready_i toggling 1/0 each cycle -> no beat skipped or duplicated; addr/data stable while ready=0; total of 32 accepted beats.
- During a dump at idx=3, write r10=0xAAAA5555 -> beat 10 reports 0xAAAA5555; the concurrent operand read of r10 also bypasses correctly.
- Assert reset_n_i at idx=7 -> valid, busy and done drop to 0 immediately; all registers read 0; a new dump_start_i begins from addr 0.

Source files
------------

// File: rtl/register_bank_pkg.sv
// register_bank_pkg: shared widths and dump FSM encoding for the register bank.
package register_bank_pkg;
  localparam int NB_DATA = 32;
  localparam int NB_ADDR = 5;
  localparam int N_REGS  = 2 ** NB_ADDR;
  typedef enum logic [1:0] {IDLE = 2'b00, SEND = 2'b01, DONE = 2'b10} dump_state_t;
endpackage

// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl: walks the register index over a valid/ready handshake and flags completion.
module reg_dump_ctrl
  import register_bank_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               dump_start_i,
  input  logic               dump_ready_i,
  output logic               dump_valid_o,
  output logic [NB_ADDR-1:0] dump_addr_o,
  output logic               dump_busy_o,
  output logic               dump_done_o
);
  dump_state_t        r_state;
  logic [NB_ADDR-1:0] r_idx;

  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else
      case (r_state)
        IDLE: if (dump_start_i) begin
          r_state <= SEND;
          r_idx   <= '0;
        end
        SEND: if (dump_ready_i) begin
          if (r_idx == '1) r_state <= DONE;
          else r_idx <= r_idx + 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

  assign dump_valid_o = r_state == SEND;
  assign dump_busy_o  = r_state != IDLE;
  assign dump_done_o  = r_state == DONE;
  assign dump_addr_o  = r_idx;
endmodule

// File: rtl/register_bank.sv
// register_bank: MIPS GPR file with write-through operand reads and a streaming dump port.
module register_bank
  import register_bank_pkg::*;
(
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic [NB_DATA-1:0] wb_data_i,
  input  logic [NB_ADDR-1:0] wb_addr_i,
  input  logic               wb_write_i,
  input  logic [NB_ADDR-1:0] rs_addr_i,
  input  logic [NB_ADDR-1:0] rt_addr_i,
  output logic [NB_DATA-1:0] rs_data_o,
  output logic [NB_DATA-1:0] rt_data_o,
  input  logic               dump_start_i,
  input  logic               dump_ready_i,
  output logic               dump_valid_o,
  output logic [NB_ADDR-1:0] dump_addr_o,
  output logic [NB_DATA-1:0] dump_data_o,
  output logic               dump_busy_o,
  output logic               dump_done_o
);
  logic [NB_DATA-1:0] r_regs [N_REGS];
  logic               w_wr;

  assign w_wr = wb_write_i && |wb_addr_i;

  // r_regs[0] is never written, so it stays at its reset value of zero
  always_ff @(posedge clock_i or negedge reset_n_i)
    if (!reset_n_i) r_regs <= '{default: '0};
    else if (w_wr) r_regs[wb_addr_i] <= wb_data_i;

  assign rs_data_o = (w_wr && wb_addr_i == rs_addr_i) ? wb_data_i : r_regs[rs_addr_i];
  assign rt_data_o = (w_wr && wb_addr_i == rt_addr_i) ? wb_data_i : r_regs[rt_addr_i];

  reg_dump_ctrl u_ctrl (
    .clock_i      (clock_i),
    .reset_n_i    (reset_n_i),
    .dump_start_i (dump_start_i),
    .dump_ready_i (dump_ready_i),
    .dump_valid_o (dump_valid_o),
    .dump_addr_o  (dump_addr_o),
    .dump_busy_o  (dump_busy_o),
    .dump_done_o  (dump_done_o)
  );

  // dump beats show stored contents only; the write bypass is for operand reads
  assign dump_data_o = dump_valid_o ? r_regs[dump_addr_o] : '0;
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed checks of reads, bypass, writes and the dump engine.
module tb_register_bank;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [31:0] wb_data = 0;
  logic [4:0]  wb_addr = 0;
  logic        wb_write = 0;
  logic [4:0]  rs_addr = 0;
  logic [4:0]  rt_addr = 0;
  logic [31:0] rs_data, rt_data, dump_data;
  logic        dump_start = 0;
  logic        dump_ready = 0;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_addr;
  logic [31:0] exp_regs [32];
  int          passed = 0;
  int          total = 0;
  int          acc;

  register_bank dut (
    .clock_i      (clk),
    .reset_n_i    (rst_n),
    .wb_data_i    (wb_data),
    .wb_addr_i    (wb_addr),
    .wb_write_i   (wb_write),
    .rs_addr_i    (rs_addr),
    .rt_addr_i    (rt_addr),
    .rs_data_o    (rs_data),
    .rt_data_o    (rt_data),
    .dump_start_i (dump_start),
    .dump_ready_i (dump_ready),
    .dump_valid_o (dump_valid),
    .dump_addr_o  (dump_addr),
    .dump_data_o  (dump_data),
    .dump_busy_o  (dump_busy),
    .dump_done_o  (dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) exp_regs[i] = 0;
    #12 rst_n = 1;
    #1;
    chk("rst_valid", 32'(dump_valid), 0);
    chk("rst_busy", 32'(dump_busy), 0);
    chk("rst_done", 32'(dump_done), 0);
    chk("rst_addr", 32'(dump_addr), 0);
    chk("rst_data", dump_data, 0);
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      chk("rst_rs", rs_data, 0);
      chk("rst_rt", rt_data, 0);
    end
    // writes to r0 are dropped, including through the bypass
    wb_write = 1; wb_addr = 0; wb_data = 32'hDEADBEEF; rs_addr = 0; rt_addr = 0;
    #1;
    chk("r0_byp_rs", rs_data, 0);
    chk("r0_byp_rt", rt_data, 0);
    step();
    wb_write = 0;
    #1;
    chk("r0_store", rs_data, 0);
    wb_write = 1; wb_addr = 5; wb_data = 32'h12345678; rs_addr = 5; rt_addr = 5;
    #1;
    chk("byp_rs", rs_data, 32'h12345678);
    chk("byp_rt", rt_data, 32'h12345678);
    step();
    wb_write = 0;
    #1;
    chk("store_rs", rs_data, 32'h12345678);
    chk("store_rt", rt_data, 32'h12345678);
    for (int i = 1; i < 32; i++) begin
      wb_write = 1; wb_addr = 5'(i); wb_data = 32'h100 + i;
      exp_regs[i] = 32'h100 + i;
      step();
    end
    wb_write = 0;
    rs_addr = 31; rt_addr = 17;
    #1;
    chk("fill_rs", rs_data, 32'h11F);
    chk("fill_rt", rt_data, 32'h111);
    // full-speed dump
    dump_start = 1; dump_ready = 1;
    step();
    dump_start = 0;
    for (int i = 0; i < 32; i++) begin
      chk("fs_valid", 32'(dump_valid), 1);
      chk("fs_addr", 32'(dump_addr), i);
      chk("fs_data", dump_data, exp_regs[i]);
      chk("fs_done", 32'(dump_done), 0);
      step();
    end
    chk("fs_done_pulse", 32'(dump_done), 1);
    chk("fs_done_valid", 32'(dump_valid), 0);
    chk("fs_done_busy", 32'(dump_busy), 1);
    dump_ready = 0;
    step();
    chk("fs_idle_done", 32'(dump_done), 0);
    chk("fs_idle_busy", 32'(dump_busy), 0);
    // ready toggling every cycle
    dump_start = 1;
    step();
    dump_start = 0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 32; c++) begin
      dump_ready = (c % 2) == 0;
      #1;
      chk("tg_valid", 32'(dump_valid), 1);
      chk("tg_addr", 32'(dump_addr), acc);
      chk("tg_data", dump_data, exp_regs[acc]);
      if (dump_ready) acc++;
      step();
    end
    dump_ready = 0;
    chk("tg_beats", acc, 32);
    chk("tg_done", 32'(dump_done), 1);
    step();
    chk("tg_idle", 32'(dump_busy), 0);
    // write r10 while the dump sits at idx 3
    dump_start = 1; dump_ready = 1;
    step();
    dump_start = 0;
    step(); step(); step();
    chk("mw_addr3", 32'(dump_addr), 3);
    wb_write = 1; wb_addr = 10; wb_data = 32'hAAAA5555; rs_addr = 10;
    exp_regs[10] = 32'hAAAA5555;
    #1;
    chk("mw_byp", rs_data, 32'hAAAA5555);
    chk("mw_beat3", dump_data, exp_regs[3]);
    step();
    wb_write = 0;
    for (int i = 4; i < 32; i++) begin
      chk("mw_addr", 32'(dump_addr), i);
      chk("mw_data", dump_data, exp_regs[i]);
      step();
    end
    chk("mw_store", rs_data, 32'hAAAA5555);
    chk("mw_done", 32'(dump_done), 1);
    step();
    // reset in the middle of a dump
    dump_start = 1;
    step();
    dump_start = 0;
    for (int i = 0; i < 7; i++) step();
    chk("rm_addr7", 32'(dump_addr), 7);
    chk("rm_data7", dump_data, exp_regs[7]);
    rst_n = 0;
    #1;
    chk("rm_valid", 32'(dump_valid), 0);
    chk("rm_busy", 32'(dump_busy), 0);
    chk("rm_done", 32'(dump_done), 0);
    for (int i = 0; i < 32; i++) exp_regs[i] = 0;
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(i);
      #1;
      chk("rm_rs", rs_data, 0);
      chk("rm_rt", rt_data, 0);
    end
    @(negedge clk);
    rst_n = 1;
    dump_start = 1;
    step();
    dump_start = 0;
    chk("rs_valid", 32'(dump_valid), 1);
    chk("rs_addr0", 32'(dump_addr), 0);
    step();
    chk("rs_addr1", 32'(dump_addr), 1);
    chk("rs_data1", dump_data, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
